// File: rtl/mc_datapath.sv
// Multi-cycle datapath: one decoded instruction at a time through IDLE -> EXEC (-> MEM),
// with an internal register file, ALU and a req/ack data-memory port guarded by a timeout.
module mc_datapath #(
    parameter int DATA_W      = 16,
    parameter int NREG        = 8,
    parameter int IMM_W       = 5,
    parameter int MEM_TIMEOUT = 16,
    localparam int RA_W       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              r_op,
    input  logic              i_op,
    input  logic              b_op,
    input  logic              l_op,
    input  logic              s_op,
    input  logic [RA_W-1:0]   rs1,
    input  logic [RA_W-1:0]   rs2,
    input  logic [RA_W-1:0]   rd,
    input  logic [IMM_W-1:0]  imm,
    input  logic              alusrc,
    input  logic [3:0]        aluctl,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              btaken,
    output logic              err
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

    state_t              state;
    logic [DATA_W-1:0]   regs [NREG];
    logic                op_alu;
    logic                op_br;
    logic                op_ld;
    logic                op_st;
    logic [RA_W-1:0]     rd_q;
    logic [3:0]          aluctl_q;
    logic                alusrc_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   imm_z;
    logic [DATA_W-1:0]   alu_b;
    logic [DATA_W-1:0]   alu_res;
    logic [CNT_W-1:0]    wait_cnt;

    assign issue_ready = (state == IDLE);
    assign imm_z       = {{(DATA_W - IMM_W){1'b0}}, imm};
    assign alu_b       = alusrc_q ? imm_q : b_q;

    // Operands come from the values captured at issue, so the ALU is stable for all of EXEC.
    always_comb begin
        alu_res = '0;
        case (aluctl_q)
            4'd0:    alu_res = a_q + alu_b;
            4'd1:    alu_res = a_q - alu_b;
            4'd2:    alu_res = a_q & alu_b;
            4'd3:    alu_res = a_q | alu_b;
            4'd4:    alu_res = a_q ^ alu_b;
            4'd5:    alu_res = a_q << alu_b[SH_W-1:0];
            4'd6:    alu_res = a_q >> alu_b[SH_W-1:0];
            4'd7:    alu_res = {{(DATA_W - 1){1'b0}}, (a_q < alu_b)};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            op_alu    <= 1'b0;
            op_br     <= 1'b0;
            op_ld     <= 1'b0;
            op_st     <= 1'b0;
            rd_q      <= '0;
            aluctl_q  <= '0;
            alusrc_q  <= 1'b0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            btaken    <= 1'b0;
            err       <= 1'b0;
        end else begin
            done   <= 1'b0;
            btaken <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_valid) begin
                        op_alu   <= r_op | i_op;
                        op_br    <= b_op;
                        op_ld    <= l_op;
                        op_st    <= s_op;
                        rd_q     <= rd;
                        aluctl_q <= aluctl;
                        alusrc_q <= alusrc;
                        imm_q    <= imm_z;
                        a_q      <= regs[rs1];
                        b_q      <= regs[rs2];
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_ld || op_st) begin
                        mem_addr  <= a_q + imm_q;
                        mem_wdata <= b_q;
                        mem_we    <= op_st;
                        mem_req   <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= MEM;
                    end else begin
                        // R0 is never written, so it keeps its reset value of zero.
                        if (op_alu && (rd_q != '0)) begin
                            regs[rd_q] <= alu_res;
                        end
                        btaken <= op_br && (alu_res == '0);
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                MEM: begin
                    // An ack arriving on the expiry cycle still completes the access.
                    if (mem_ack) begin
                        if (op_ld && (rd_q != '0)) begin
                            regs[rd_q] <= mem_rdata;
                        end
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end else if ((MEM_TIMEOUT != 0) && ((wait_cnt + CNT_W'(1)) == TIMEOUT_CNT)) begin
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
